// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver:
//   rx_state_t    : receiver FSM state encoding
//   DATA_BITS     : data bits per frame
//   PE/FE/OE_BIT  : status bit positions inside the 32-bit Dout word
//   data_parity() : even-parity bit (XOR) of a data byte
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   localparam int DATA_BITS = 8;
   localparam int PE_BIT    = 8;
   localparam int FE_BIT    = 9;
   localparam int OE_BIT    = 10;

   function automatic logic data_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer bringing the asynchronous serial line into the
// Clock domain. Both flops reset to 1 so a reset never looks like a start bit.
// Ports:
//   Clock : system clock
//   Reset : synchronous, active-high reset
//   din   : asynchronous serial input
//   dout  : synchronized line value (second flop)
// ---------------------------------------------------------------------------
module uart_rx_sync (
   input  logic Clock,
   input  logic Reset,
   input  logic din,
   output logic dout
);

   logic meta;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         meta <= 1'b1;
         dout <= 1'b1;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// 8E1 UART receiver with a one-deep holding register and status flags.
// Frame: start(0), 8 data bits LSB first, even parity, stop(1); each bit is
// CLKS_PER_BIT clocks wide.
// Ports:
//   Clock : system clock, rising edge
//   Reset : synchronous, active-high reset
//   RxD   : serial line, idle high, asynchronous
//   RD    : one-cycle read strobe, acknowledges the held byte
//   Dout  : {21'b0, OE, FE, PE, data[7:0]}
//   RxRDY : an unread frame is held in Dout
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for rx_s low (start bit edge)
// START  | counting to mid start bit; high there means false start
// DATA   | sampling 8 data bits at bit centres
// PARITY | sampling the parity bit, recording PE
// STOP   | sampling the stop bit; frame completes here
// ---------------------------------------------------------------------------
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        RxD,
   input  logic        RD,
   output logic [31:0] Dout,
   output logic        RxRDY
);

   localparam int          HALF       = (CLKS_PER_BIT - 1) / 2;
   localparam logic [15:0] CNT_RELOAD = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LOAD  = 16'((HALF > 0) ? (HALF - 1) : 0);
   localparam logic [2:0]  LAST_BIT   = 3'(DATA_BITS - 1);

   rx_state_t              state;
   logic [15:0]            cnt;
   logic [2:0]             bit_idx;
   logic [DATA_BITS-1:0]   shreg;
   logic                   par_err;
   logic                   rx_s;
   logic                   frame_done;

   logic [DATA_BITS-1:0]   data_r;
   logic                   pe_r;
   logic                   fe_r;
   logic                   oe_r;

   uart_rx_sync u_sync (
      .Clock (Clock),
      .Reset (Reset),
      .din   (RxD),
      .dout  (rx_s)
   );

   // The stop sample happens in the cycle where STOP reaches cnt==0.
   assign frame_done = (state == STOP) && (cnt == 16'd0);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         cnt     <= 16'd0;
         bit_idx <= 3'd0;
         shreg   <= '0;
         par_err <= 1'b0;
         data_r  <= '0;
         pe_r    <= 1'b0;
         fe_r    <= 1'b0;
         oe_r    <= 1'b0;
         RxRDY   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  bit_idx <= 3'd0;
                  // With one or two clocks per bit there is no room to wait
                  // for mid start bit; go straight to data sampling.
                  if (HALF == 0) begin
                     state <= DATA;
                     cnt   <= CNT_RELOAD;
                  end else begin
                     state <= START;
                     cnt   <= HALF_LOAD;
                  end
               end
            end
            START: begin
               if (cnt == 16'd0) begin
                  if (!rx_s) begin
                     state   <= DATA;
                     cnt     <= CNT_RELOAD;
                     bit_idx <= 3'd0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            DATA: begin
               if (cnt == 16'd0) begin
                  // Shift in at the MSB so the first bit ends up at bit 0.
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  cnt   <= CNT_RELOAD;
                  if (bit_idx == LAST_BIT) begin
                     state <= PARITY;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            PARITY: begin
               if (cnt == 16'd0) begin
                  par_err <= (rx_s != data_parity(shreg));
                  cnt     <= CNT_RELOAD;
                  state   <= STOP;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            STOP: begin
               if (cnt == 16'd0) begin
                  cnt   <= CNT_RELOAD;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 16'd0;
            end
         endcase

         // Holding register: a read in the completion cycle frees the slot
         // for the new frame; otherwise an unread byte blocks it (overrun).
         if (frame_done) begin
            if (!RxRDY || RD) begin
               data_r <= shreg;
               pe_r   <= par_err;
               fe_r   <= ~rx_s;
               oe_r   <= 1'b0;
               RxRDY  <= 1'b1;
            end else begin
               oe_r <= 1'b1;
            end
         end else if (RD && RxRDY) begin
            RxRDY <= 1'b0;
            oe_r  <= 1'b0;
         end
      end
   end

   always_comb begin
      Dout                  = '0;
      Dout[DATA_BITS-1:0]   = data_r;
      Dout[PE_BIT]          = pe_r;
      Dout[FE_BIT]          = fe_r;
      Dout[OE_BIT]          = oe_r;
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1, Clock cycles per serial bit; legal range 1..65535.
REQ-002 SHALL have port Clock  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset, sampled on Clock rising edge.
REQ-004 SHALL have port RxD  input  1  serial line; idle high; asynchronous to Clock.
REQ-005 SHALL have port RD  input  1  one-cycle read strobe from CPU; acknowledges the held byte.
REQ-006 SHALL have port Dout  output  32  {21'b0, OE, FE, PE, data[7:0]}, registered.
REQ-007 SHALL have port RxRDY  output  1  high while an unread frame is held in Dout.

Function
REQ-008 SHALL accept frames of: start(0), 8 data bits LSB first, even-parity bit (XOR of the data bits), stop(1), each CLKS_PER_BIT clocks wide.
REQ-009 SHALL pass RxD through a 2-flop synchronizer; rx_s (second flop) is the only line value the FSM uses.
REQ-010 FSM states SHALL be IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; HALF = (CLKS_PER_BIT-1)/2, integer division.
REQ-011 IDLE, rx_s==0: if HALF==0 -> DATA with cnt=CLKS_PER_BIT-1, bit index 0; else -> START with cnt=HALF-1.
REQ-012 START: decrement cnt; at cnt==0, rx_s==0 -> DATA with cnt=CLKS_PER_BIT-1; rx_s==1 (false start) -> IDLE, no flags change.
REQ-013 DATA/PARITY/STOP: decrement cnt; at cnt==0 sample rx_s, reload cnt=CLKS_PER_BIT-1, advance after the 8th data sample, the parity sample, and the stop sample.
REQ-014 Each data sample SHALL shift into an 8-bit shift register at bit [7]; after 8 samples, bit [0] holds the first data bit received.
REQ-015 PE SHALL be set when the parity sample != XOR of the 8 data bits; FE SHALL be set when the stop sample == 0.
REQ-016 On the stop sample the FSM SHALL return to IDLE; a further rx_s==0 in IDLE on the next cycle starts a new frame (back-to-back frames).
REQ-017 Frame completion with RxRDY==0, or with RD==1 in the same cycle: Dout[9:0] <= {FE,PE,data}, RxRDY stays/goes 1, OE <= 0.
REQ-018 Frame completion with RxRDY==1 and RD==0: the new frame is discarded, Dout[9:0] is unchanged, and OE (Dout[10]) <= 1.
REQ-019 RD==1 with no completion in that cycle: RxRDY <= 0 and OE <= 0; Dout[9:0] holds. RD while RxRDY==0 has no effect.
REQ-020 Latency: with CLKS_PER_BIT=1, RxRDY SHALL rise on the 3rd rising edge after the edge that drives the stop bit onto RxD.
REQ-021 A frame that ends with FE set SHALL still be delivered per REQ-017/018; the receiver does not resynchronize beyond returning to IDLE.

Reset
REQ-022 Reset SHALL force the FSM to IDLE, cnt and bit index to 0, both synchronizer flops to 1, Dout to 0, and RxRDY to 0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame; no partial data or flags SHALL appear in Dout.
REQ-024 Reset SHALL take priority over RD and over frame completion in the same cycle.

Structure
REQ-025 A shared package uart_pkg SHALL hold the state encodings (REQ-010), DATA_BITS=8, and the status bit positions PE=8, FE=9, OE=10.
REQ-026 The synchronizer SHALL be sub-module uart_rx_sync (Clock, Reset, din, dout; reset value 1); everything else SHALL live in uart_receiver.

Verification
REQ-027 Loopback test: existing transmitter TxD -> RxD, CLKS_PER_BIT=1, write 0x000000A5 -> Dout=0x000000A5, RxRDY=1 per REQ-020 timing.
REQ-028 Parity error: frame data 0x3C with parity bit 1 -> Dout=0x0000013C, RxRDY=1.
REQ-029 Framing error: frame data 0x81 with correct parity 0 and stop bit 0 -> Dout=0x00000281.
REQ-030 Overrun: receive 0x11 with no RD, then receive 0x22 -> Dout=0x00000411; then RD pulse -> RxRDY=0, Dout=0x00000011.
REQ-031 Glitch rejection: CLKS_PER_BIT=16, RxD low for 3 clocks then high -> FSM returns to IDLE, RxRDY stays 0; a following valid 0x5A frame -> Dout=0x0000005A.
REQ-032 Reset mid-frame: assert Reset after data bit 4 of 0xFF -> Dout=0, RxRDY=0; a following frame 0x0F -> Dout=0x0000000F.
